// File: rtl/apb4_mst_pkg.sv
// Shared types and constants for the APB4 command master.
package apb4_mst_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb4_mst_state_e;

  localparam logic [2:0] APB4_MST_PROT_DEFAULT = 3'b000;

  // True while a transfer occupies the master and new commands must stall.
  function automatic logic apb4_mst_busy(input apb4_mst_state_e st);
    return st != IDLE;
  endfunction

endpackage

// File: rtl/apb4_mst_wdog.sv
// ACCESS-phase watchdog: counts stalled ACCESS cycles and flags the cycle
// in which the count reaches LIMIT. Only built with APB4_MST_TIMEOUT_EN.
module apb4_mst_wdog #(
  parameter int unsigned LIMIT = 256
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Expired is asserted during the stalled cycle whose increment hits LIMIT.
  assign expired_o = en_i && (cnt_q == CW'(LIMIT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/apb4_cmd_master.sv
// APB4 initiator turning single command beats into SETUP/ACCESS transfers.
// Optional ACCESS timeout is enabled by defining APB4_MST_TIMEOUT_EN.
module apb4_cmd_master
  import apb4_mst_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    cmd_valid_i,
  output logic                    cmd_ready_o,
  input  logic                    cmd_write_i,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr_i,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] cmd_strb_i,
  input  logic [2:0]              cmd_prot_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
  output logic                    rsp_err_o,
  output logic                    rsp_timeout_o,
  output logic [ADDR_WIDTH-1:0]   paddr_o,
  output logic [2:0]              pprot_o,
  output logic                    psel_o,
  output logic                    penable_o,
  output logic                    pwrite_o,
  output logic [DATA_WIDTH-1:0]   pwdata_o,
  output logic [DATA_WIDTH/8-1:0] pstrb_o,
  input  logic                    pready_i,
  input  logic [DATA_WIDTH-1:0]   prdata_i,
  input  logic                    pslverr_i
);

  localparam int SW = DATA_WIDTH / 8;

  // Both channels transfer on a cycle where valid and ready are high at the
  // clock edge; valid is never withdrawn and payload is held until then.

  apb4_mst_state_e state_q, state_d;

  logic                  cmd_ready_q, cmd_ready_d;
  logic                  psel_q, psel_d;
  logic                  penable_q, penable_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic                  pwrite_q, pwrite_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic [SW-1:0]         pstrb_q, pstrb_d;
  logic [2:0]            pprot_q, pprot_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  rsp_timeout_q, rsp_timeout_d;

  logic cmd_accept;
  logic timeout_hit;

  assign cmd_accept = cmd_valid_i && !apb4_mst_busy(state_q);

`ifdef APB4_MST_TIMEOUT_EN
  apb4_mst_wdog #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_wdog (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clear_i   (state_q == SETUP),
    .en_i      ((state_q == ACCESS) && !pready_i),
    .expired_o (timeout_hit)
  );

  logic unused_cfg;
  assign unused_cfg = ^cmd_addr_i[1:0];
`else
  assign timeout_hit = 1'b0;

  // Address LSBs are dropped by word alignment; the limit has no watchdog here.
  logic unused_cfg;
  assign unused_cfg = ^{cmd_addr_i[1:0], TIMEOUT_CYCLES};
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (cmd_valid_i) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (pready_i || timeout_hit) state_d = RESP;
      RESP:    if (rsp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output values are derived from the next state so every port is a flop.
  always_comb begin
    cmd_ready_d   = (state_d == IDLE);
    psel_d        = (state_d == SETUP) || (state_d == ACCESS);
    penable_d     = (state_d == ACCESS);
    rsp_valid_d   = (state_d == RESP);
    paddr_d       = paddr_q;
    pwrite_d      = pwrite_q;
    pwdata_d      = pwdata_q;
    pstrb_d       = pstrb_q;
    pprot_d       = pprot_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;

    if (cmd_accept) begin
      paddr_d  = {cmd_addr_i[ADDR_WIDTH-1:2], 2'b00};
      pwrite_d = cmd_write_i;
      pwdata_d = cmd_wdata_i;
      pstrb_d  = cmd_write_i ? cmd_strb_i : '0;
      pprot_d  = cmd_prot_i;
    end

    // A responder completion in the limit cycle takes priority over timeout.
    if (state_q == ACCESS) begin
      if (pready_i) begin
        rsp_rdata_d   = pwrite_q ? '0 : prdata_i;
        rsp_err_d     = pslverr_i;
        rsp_timeout_d = 1'b0;
      end else if (timeout_hit) begin
        rsp_rdata_d   = '0;
        rsp_err_d     = 1'b1;
        rsp_timeout_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cmd_ready_q   <= 1'b1;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      paddr_q       <= '0;
      pwrite_q      <= 1'b0;
      pwdata_q      <= '0;
      pstrb_q       <= '0;
      pprot_q       <= APB4_MST_PROT_DEFAULT;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      cmd_ready_q   <= cmd_ready_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      paddr_q       <= paddr_d;
      pwrite_q      <= pwrite_d;
      pwdata_q      <= pwdata_d;
      pstrb_q       <= pstrb_d;
      pprot_q       <= pprot_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign cmd_ready_o   = cmd_ready_q;
  assign psel_o        = psel_q;
  assign penable_o     = penable_q;
  assign paddr_o       = paddr_q;
  assign pwrite_o      = pwrite_q;
  assign pwdata_o      = pwdata_q;
  assign pstrb_o       = pstrb_q;
  assign pprot_o       = pprot_q;
  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_rdata_o   = rsp_rdata_q;
  assign rsp_err_o     = rsp_err_q;
  assign rsp_timeout_o = rsp_timeout_q;

endmodule
